// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences L0 fetch, MAC kernel-load/execute, OFIFO drain into psum SRAM, then SFU accumulate/ReLU replay.
// Optional: define CORELET_CTRL_RELU_EN to assert relu during ACC_OUT; otherwise relu is tied low.
module corelet_ctrl #(
    parameter int bw       = 4,
    parameter int psum_bw  = 16,
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_kij  = 9,
    parameter int len_nij  = 36,
    parameter int len_onij = 16,
    parameter int addr_bw  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               xmem_cen,
    output logic [addr_bw-1:0] xmem_addr,
    input  logic [bw*row-1:0]  xmem_q,
    output logic [bw*row-1:0]  data_to_l0,
    output logic               l0_wr,
    output logic               l0_rd,
    input  logic               l0_full,
    input  logic               l0_ready,
    output logic [1:0]         inst,
    output logic               ofifo_rd,
    input  logic               ofifo_valid,
    input  logic               ofifo_full,
    output logic               pmem_cen,
    output logic               pmem_wen,
    output logic [addr_bw-1:0] pmem_addr,
    output logic               accumulate,
    output logic               relu
);
    if (psum_bw < 1) begin : g_psum_bw_check
        $error("psum_bw must be positive");
    end

    typedef enum logic [3:0] {IDLE, W_FILL, W_LOAD, W_SETTLE, X_RUN, X_DRAIN, ACC, ACC_OUT, DONE} state_t;
    state_t state, state_n;

    localparam logic [addr_bw-1:0] n_col       = addr_bw'(col);
    localparam logic [addr_bw-1:0] n_kij       = addr_bw'(len_kij);
    localparam logic [addr_bw-1:0] n_nij       = addr_bw'(len_nij);
    localparam logic [addr_bw-1:0] col_last    = addr_bw'(col - 1);
    localparam logic [addr_bw-1:0] kij_last    = addr_bw'(len_kij - 1);
    localparam logic [addr_bw-1:0] nij_last    = addr_bw'(len_nij - 1);
    localparam logic [addr_bw-1:0] onij_last   = addr_bw'(len_onij - 1);
    localparam logic [addr_bw-1:0] settle_last = addr_bw'(row + col - 1);

    logic [addr_bw-1:0] kij, cnt, rcnt, wcnt, d, o, n_fetch;
    logic               pend, hold_v, acc_q, fetch, cur_v, issue, drain_st, acc_rd, cnt_inc, last_kij;
    logic [bw*row-1:0]  hold_d;

    // The holding slot is logically full either while a read is in flight (data on xmem_q) or after capture.
    assign fetch      = state == W_FILL || state == X_RUN;
    assign n_fetch    = state == X_RUN ? n_nij : n_col;
    assign cur_v      = hold_v | pend;
    assign data_to_l0 = hold_v ? hold_d : xmem_q;
    assign l0_wr      = cur_v & ~l0_full;
    assign issue      = fetch && rcnt != n_fetch && (!cur_v || l0_wr);
    assign xmem_cen   = ~issue;
    assign xmem_addr  = (state == X_RUN ? n_kij * n_col : kij * n_col) + rcnt;

    assign l0_rd      = (state == W_LOAD && l0_ready) || (state == X_RUN && l0_ready && !ofifo_full);
    assign inst       = {state == X_RUN && l0_rd, state == W_LOAD && l0_rd};

    assign drain_st   = state == X_RUN || state == X_DRAIN;
    assign ofifo_rd   = drain_st && ofifo_valid && d != n_nij;
    assign acc_rd     = state == ACC && cnt != n_kij;
    assign pmem_cen   = ~(ofifo_rd | acc_rd);
    assign pmem_wen   = ~ofifo_rd;
    assign pmem_addr  = state == ACC ? cnt * n_nij + o : kij * n_nij + d;

    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign accumulate = acc_q;
`ifdef CORELET_CTRL_RELU_EN
    assign relu       = state == ACC_OUT;
`else
    assign relu       = 1'b0;
`endif

    assign last_kij   = kij == kij_last;
    assign cnt_inc    = (state == W_LOAD || state == X_RUN) ? l0_rd : (state == W_SETTLE || state == ACC);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = W_FILL;
            W_FILL:   if (l0_wr && wcnt == col_last) state_n = W_LOAD;
            W_LOAD:   if (l0_rd && cnt == col_last) state_n = W_SETTLE;
            W_SETTLE: if (cnt == settle_last) state_n = X_RUN;
            X_RUN:    if (l0_rd && cnt == nij_last) state_n = X_DRAIN;
            X_DRAIN:  if (d == n_nij) state_n = last_kij ? ACC : W_FILL;
            ACC:      if (cnt == n_kij) state_n = ACC_OUT;
            ACC_OUT:  state_n = o == onij_last ? DONE : ACC;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            kij    <= '0;
            cnt    <= '0;
            rcnt   <= '0;
            wcnt   <= '0;
            d      <= '0;
            o      <= '0;
            pend   <= 1'b0;
            hold_v <= 1'b0;
            hold_d <= '0;
            acc_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= state_n != state ? '0 : cnt + addr_bw'(cnt_inc);
            rcnt   <= fetch ? rcnt + addr_bw'(issue) : '0;
            wcnt   <= fetch ? wcnt + addr_bw'(l0_wr) : '0;
            pend   <= issue;
            hold_v <= cur_v & ~l0_wr;
            hold_d <= pend ? xmem_q : hold_d;
            d      <= drain_st ? d + addr_bw'(ofifo_rd) : '0;
            kij    <= (state == X_DRAIN && d == n_nij) ? (last_kij ? '0 : kij + 1'b1) : kij;
            o      <= state == ACC_OUT ? (o == onij_last ? '0 : o + 1'b1) : o;
            acc_q  <= acc_rd;
        end
    end
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: scoreboard bench with behavioural SRAM/L0/MAC/OFIFO models and randomized stalls around corelet_ctrl.
module tb_corelet_ctrl;
    localparam int COL = 8, KIJ = 9, NIJ = 36, ONIJ = 16, AW = 11;
`ifdef CORELET_CTRL_RELU_EN
    localparam int EXP_RELU = ONIJ;
`else
    localparam int EXP_RELU = 0;
`endif

    logic clk = 0, reset = 1, start = 0;
    logic busy, done, xmem_cen, l0_wr, l0_rd, ofifo_rd, pmem_cen, pmem_wen, accumulate, relu;
    logic [AW-1:0] xmem_addr, pmem_addr;
    logic [31:0] xmem_q = '0, data_to_l0;
    logic [1:0] inst;
    logic l0_full = 0, l0_ready = 0, ofifo_valid = 0, ofifo_full = 0;

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .xmem_q(xmem_q), .data_to_l0(data_to_l0),
        .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_full(l0_full), .l0_ready(l0_ready), .inst(inst),
        .ofifo_rd(ofifo_rd), .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
        .accumulate(accumulate), .relu(relu)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    int acc_cnt, relu_cnt, done_cnt, pw_last, last_acc;
    logic [31:0] exp_l0w[$];
    int exp_inst[$], exp_pw[$], exp_acc[$];
    logic [31:0] l0q[$];
    int mac_t[$];
    int ofq = 0;
    logic [1:0] stall_mode = 0;
    logic dir_l0 = 0, prev_rd = 0, prev_acc = 0;
    logic s_rd, s_wr, s_pop, s_ord;
    logic [AW-1:0] s_addr;
    logic [31:0] s_data;
    logic [1:0] s_inst;

    function automatic logic [31:0] vec(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h3C5A_0F17;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot DUT requests mid-cycle; the environment commits them just after the edge.
    always @(negedge clk) begin
        s_rd = !reset && !xmem_cen; s_addr = xmem_addr;
        s_wr = !reset && l0_wr; s_data = data_to_l0;
        s_pop = !reset && l0_rd; s_inst = inst;
        s_ord = !reset && ofifo_rd;
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            l0q.delete(); mac_t.delete(); ofq = 0; xmem_q = '0;
        end else begin
            xmem_q = s_rd ? vec(s_addr) : $urandom;
            if (s_wr) l0q.push_back(s_data);
            if (s_pop && l0q.size() > 0) void'(l0q.pop_front());
            if (s_pop && s_inst == 2'b10) mac_t.push_back(cyc + 3);
            if (s_ord && ofq > 0) ofq--;
            while (mac_t.size() > 0 && mac_t[0] <= cyc) begin
                void'(mac_t.pop_front());
                ofq++;
            end
        end
        l0_full     = dir_l0 || (stall_mode[0] && $urandom_range(0, 3) == 0) || l0q.size() >= 16;
        l0_ready    = l0q.size() > 0;
        ofifo_valid = ofq > 0;
        ofifo_full  = (stall_mode[1] && $urandom_range(0, 2) == 0) || ofq >= 16;
    end

    // Monitor: pops expected responses whenever the DUT presents an event.
    always @(negedge clk) begin
        if (reset) begin
            prev_rd = 0; prev_acc = 0;
        end else begin
            if (l0_wr) begin
                if (exp_l0w.size() == 0) chk("l0_wr_extra", 1, 0);
                else chk("l0_data", data_to_l0, exp_l0w.pop_front());
                chk("l0_wr_while_full", l0_full, 0);
            end
            if (l0_rd) begin
                if (exp_inst.size() == 0) chk("pop_extra", 1, 0);
                else chk("pop_inst", inst, exp_inst.pop_front());
                if (inst == 2'b10) chk("exec_while_ofifo_full", ofifo_full, 0);
            end else if (inst != 2'b00) chk("inst_without_pop", inst, 0);
            if (ofifo_rd || (!pmem_cen && !pmem_wen)) begin
                chk("drain_coincident", {ofifo_rd, pmem_cen, pmem_wen}, 3'b100);
                chk("ofifo_rd_valid", ofifo_valid, 1);
                if (exp_pw.size() == 0) chk("psum_wr_extra", 1, 0);
                else chk("psum_wr_addr", pmem_addr, exp_pw.pop_front());
                pw_last = int'(pmem_addr);
            end
            if (!pmem_cen && pmem_wen) begin
                if (exp_acc.size() == 0) chk("acc_rd_extra", 1, 0);
                else chk("acc_rd_addr", pmem_addr, exp_acc.pop_front());
                last_acc = int'(pmem_addr);
            end
            if (accumulate || prev_rd) chk("acc_after_read", accumulate, prev_rd);
            if (relu) chk("relu_after_last_acc", {prev_acc, accumulate}, 2'b10);
            prev_rd = !pmem_cen && pmem_wen;
            prev_acc = accumulate;
            acc_cnt += int'(accumulate);
            relu_cnt += int'(relu);
            done_cnt += int'(done);
        end
    end

    task automatic load_expect();
        exp_l0w.delete(); exp_inst.delete(); exp_pw.delete(); exp_acc.delete();
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i < COL; i++) begin
                exp_l0w.push_back(vec(AW'(k * COL + i)));
                exp_inst.push_back(1);
            end
            for (int n = 0; n < NIJ; n++) begin
                exp_l0w.push_back(vec(AW'(KIJ * COL + n)));
                exp_inst.push_back(2);
                exp_pw.push_back(k * NIJ + n);
            end
        end
        for (int o = 0; o < ONIJ; o++)
            for (int k = 0; k < KIJ; k++) exp_acc.push_back(k * NIJ + o);
        acc_cnt = 0; relu_cnt = 0; done_cnt = 0; pw_last = -1; last_acc = -1;
    endtask

    task automatic kick(input bit directed_stall);
        @(posedge clk); #1 start = 1;
        @(negedge clk); chk("busy_before_start", busy, 0);
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("first_read_cen", xmem_cen, 0);
        chk("first_read_addr", xmem_addr, 0);
        chk("busy_after_start", busy, 1);
        @(negedge clk);
        if (!stall_mode[0]) chk("first_l0_wr", l0_wr, 1);
        if (directed_stall) begin
            @(negedge clk); dir_l0 = 1;
            repeat (5) @(negedge clk);
            dir_l0 = 0;
        end
    endtask

    task automatic run_job(input logic [1:0] mode, input bit directed_stall, input bit extra_starts);
        int i;
        stall_mode = mode;
        load_expect();
        kick(directed_stall);
        for (i = 0; i < 8000 && done_cnt == 0; i++) begin
            @(negedge clk);
            start = extra_starts && (i == 50 || i == 400);
        end
        start = 0;
        chk("done_within_budget", done_cnt, 1);
        repeat (10) @(negedge clk);
        chk("idle_after_done", busy, 0);
        chk("single_done", done_cnt, 1);
        chk("l0_writes_left", exp_l0w.size(), 0);
        chk("pops_left", exp_inst.size(), 0);
        chk("psum_writes_left", exp_pw.size(), 0);
        chk("acc_reads_left", exp_acc.size(), 0);
        chk("acc_cycles", acc_cnt, KIJ * ONIJ);
        chk("relu_strobes", relu_cnt, EXP_RELU);
        chk("last_acc_addr", last_acc, (KIJ - 1) * NIJ + ONIJ - 1);
        stall_mode = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_inst", inst, 0);
        chk("rst_strobes", {l0_wr, l0_rd, ofifo_rd, accumulate, relu, done, busy}, 0);
        chk("rst_enables", {xmem_cen, pmem_cen, pmem_wen}, 3'b111);
        chk("rst_xmem_addr", xmem_addr, 0);
        chk("rst_pmem_addr", pmem_addr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 0;
        run_job(2'b00, 1, 0);
        run_job(2'b01, 0, 1);
        run_job(2'b10, 0, 0);
        // Abort in the middle of the fourth kernel position's execute phase.
        load_expect();
        kick(0);
        for (int i = 0; i < 5000 && pw_last != 3 * NIJ; i++) @(negedge clk);
        chk("reached_kij3", pw_last, 3 * NIJ);
        @(posedge clk); #1 reset = 1;
        #1 check_reset_values();
        exp_l0w.delete(); exp_inst.delete(); exp_pw.delete(); exp_acc.delete();
        repeat (2) @(negedge clk);
        reset = 0;
        run_job(2'b11, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
